// File: rtl/data_ram_resp_pkg.sv
// Shared constants, FSM state type and byte-lane legality helper for the MEM-stage data RAM.
package data_ram_resp_pkg;

    localparam int unsigned RegBus      = 32;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        DramIdle,
        DramBusy,
        DramResp
    } dram_state_e;

    // Word, aligned halfword and single byte lane patterns are the only legal selects.
    function automatic logic sel_legal(input logic [3:0] sel);
        unique case (sel)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_legal = 1'b1;
            default:                           sel_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word storage with per-byte write enables and a registered read port that holds its last value.
module data_ram_array
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            sel_i,
    input  logic [RegBus-1:0]     wdata_i,
    output logic [RegBus-1:0]     rdata_o
);

    logic [RegBus-1:0] mem_q [2**ADDR_WIDTH];
    logic [RegBus-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rdata_q <= ZeroWord;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data-memory responder: latches one request, waits WAIT_CYCLES, then acks for a cycle.
// Optional lane-pattern checking and mem_err_o are enabled by defining DATA_RAM_ALIGN_CHECK_EN.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_ack_o,
`ifdef DATA_RAM_ALIGN_CHECK_EN
    output logic              mem_err_o,
`endif
    output logic              stallreq_o
);

    localparam logic [3:0] LastCnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dram_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  commit, acc_ok, arr_we, arr_re;
    logic                  unused_addr;

    assign unused_addr = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        unique case (state_q)
            DramIdle: begin
                if (mem_ce_i == ChipEnable) begin
                    we_d    = mem_we_i;
                    idx_d   = mem_addr_i[ADDR_WIDTH+1:2];
                    sel_d   = mem_sel_i;
                    wdata_d = mem_data_i;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? DramResp : DramBusy;
                end
            end
            DramBusy: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = 4'd0;
                    state_d = DramResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DramResp: state_d = DramIdle;
            default:  state_d = DramIdle;
        endcase
    end

    // The _d copies equal the live inputs on a zero-wait acceptance, the latches otherwise.
    assign commit = (state_d == DramResp) && (state_q != DramResp) && (rst != RstEnable);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign acc_ok = sel_legal(sel_d);
`else
    assign acc_ok = 1'b1;
`endif
    assign arr_we = commit && (we_d == WriteEnable) && acc_ok;
    assign arr_re = commit && (we_d != WriteEnable) && acc_ok;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= DramIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    data_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (idx_d),
        .sel_i   (sel_d),
        .wdata_i (wdata_d),
        .rdata_o (mem_data_o)
    );

    assign mem_ack_o  = (state_q == DramResp);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign mem_err_o  = mem_ack_o && !sel_legal(sel_q);
`endif
    assign stallreq_o = mem_ce_i & ~mem_ack_o;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed and randomized bench for data_ram_resp against a word-array reference model.
module tb_data_ram_resp;

    localparam int unsigned AW = 10;
    localparam int unsigned W  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic [3:0]  mem_sel_i;
    logic        mem_ack_o, stallreq_o;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    logic        mem_err_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [1024];
    bit          valid [1024];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    data_ram_resp #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_ack_o  (mem_ack_o),
`ifdef DATA_RAM_ALIGN_CHECK_EN
        .mem_err_o  (mem_err_o),
`endif
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] sel);
`ifdef DATA_RAM_ALIGN_CHECK_EN
        return sel inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
`else
        return 1'b1;
`endif
    endfunction

    // One full request: drive, scramble inputs after acceptance, expect ack exactly W edges later.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data);
        int          lat;
        bit          got;
        int unsigned idx;
        logic [31:0] r;
        idx = int'(addr[AW+1:2]);
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        @(posedge clk);
        #1;
        r = $urandom; mem_data_i = r;
        r = $urandom; mem_addr_i = r;
        mem_sel_i = 4'($urandom); mem_we_i = 1'($urandom);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k <= int'(W) + 3 && !got; k++) begin
            @(negedge clk);
            if (mem_ack_o) begin
                got = 1'b1;
                lat = k;
            end else begin
                check("stall_while_busy", 32'(stallreq_o), 32'd1);
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_latency", lat, W);
            check("stall_at_ack", 32'(stallreq_o), 32'd0);
`ifdef DATA_RAM_ALIGN_CHECK_EN
            check("err_flag", 32'(mem_err_o), 32'(!legal(sel)));
`endif
            if (legal(sel)) begin
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (sel[i]) model[idx][8*i +: 8] = data[8*i +: 8];
                    valid[idx] = 1'b1;
                end else begin
                    last_rd = model[idx];
                end
            end
            check(we ? "data_hold_on_write" : "read_data", mem_data_o, last_rd);
        end
        mem_ce_i = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(mem_ack_o), 32'd0);
    endtask

    initial begin
        logic [31:0] r, addr;
        int unsigned slots [8];
        rst = 1'b1; mem_ce_i = 1'b1; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_sel_i = 4'hF; mem_data_i = '0;
        last_rd = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ack", 32'(mem_ack_o), 32'd0);
            check("rst_data", mem_data_o, 32'd0);
            check("rst_stall", 32'(stallreq_o), 32'd1);
        end
        rst = 1'b0; mem_ce_i = 1'b0;
        #1;
        check("idle_stall", 32'(stallreq_o), 32'd0);

        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        access(1'b0, 32'h10, 4'hF, 32'h0);
        access(1'b1, 32'h20, 4'hF, 32'h11223344);
        access(1'b1, 32'h20, 4'h1, 32'h000000AA);
        access(1'b0, 32'h20, 4'hF, 32'h0);
        check("byte_lane_value", last_rd, 32'h112233AA);
        access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
        access(1'b0, 32'h20, 4'hF, 32'h0);
        access(1'b1, 32'h1000, 4'hF, 32'h55);
        access(1'b0, 32'h0000, 4'hF, 32'h0);
        check("wrap_value", last_rd, 32'h55);

        // Reset one cycle after acceptance aborts the write.
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h10; mem_sel_i = 4'hF;
        mem_data_i = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1; mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 4; i++) begin
            check("no_ack_after_rst", 32'(mem_ack_o), 32'd0);
            @(negedge clk);
        end
        access(1'b0, 32'h10, 4'hF, 32'h0);
        check("abort_kept_old", last_rd, 32'hDEADBEEF);

`ifdef DATA_RAM_ALIGN_CHECK_EN
        access(1'b1, 32'h10, 4'b0110, 32'h12345678);
        access(1'b1, 32'h10, 4'b1100, 32'hABCD0000);
        access(1'b0, 32'h10, 4'hF, 32'h0);
        check("align_value", last_rd, 32'hABCDBEEF);
`endif

        for (int j = 0; j < 8; j++) slots[j] = $urandom_range(0, 1023);
        for (int i = 0; i < 40; i++) begin
            int   j;
            logic we;
            logic [3:0] sel;
            j = $urandom_range(0, 7);
            r = $urandom;
            addr = {r[31:AW+2], slots[j][AW-1:0], r[1:0]};
            we  = 1'($urandom);
            sel = 4'($urandom);
            if (!valid[slots[j]]) begin
                we = 1'b1;
                sel = 4'hF;
            end
            access(we, addr, sel, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
